// File: rtl/intr_vec_decoder_pkg.sv
// Shared constants and the service-FSM state type for the interrupt-vector receiver.
package intr_pkg;

   localparam int PORTS          = 32;
   localparam int NUM_W          = $clog2(PORTS);
   localparam int INTR_CYCLES    = 2;
   localparam int MIN_REQ_CYCLES = INTR_CYCLES;
   localparam int STATE_BITS     = 2;

   typedef enum logic [STATE_BITS-1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      GAP     = 2'd2
   } state_e;

endpackage

// File: rtl/intr_vec_decoder_prienc.sv
// Generic priority encoder: reports the index of the winning set bit and whether any bit is set.
module priority_encoder #(
   parameter int WIDTH             = 32,
   parameter bit LSB_HIGH_PRIORITY = 1'b1,
   parameter int IDX_W             = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] req_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   // Scan toward the highest-priority end so that the last hit wins.
   always_comb begin
      idx_o   = '0;
      valid_o = |req_i;
      if (LSB_HIGH_PRIORITY) begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = IDX_W'(i);
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (req_i[i]) idx_o = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/intr_vec_decoder.sv
// Turns interrupt-vector pulses back into pending bits and serves the highest-priority
// enabled one to a consumer over valid/ready, flagging overruns and protocol errors.
module intr_vec_decoder
   import intr_pkg::*;
#(
   parameter int             PORTS          = intr_pkg::PORTS,
   parameter int             MIN_REQ_CYCLES = intr_pkg::MIN_REQ_CYCLES,
   parameter logic [PORTS-1:0] EN_RESET     = {PORTS{1'b1}},
   parameter int             NW             = $clog2(PORTS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             intr_vec_req,
   input  logic [NW-1:0]    intr_num,
   input  logic             en_wr,
   input  logic [PORTS-1:0] en_wr_data,
   output logic [PORTS-1:0] enable,
   output logic [PORTS-1:0] pending,
   output logic [PORTS-1:0] overrun,
   input  logic             err_clr,
   output logic             proto_err,
   output logic             irq,
   output logic             irq_valid,
   output logic [NW-1:0]    irq_num,
   input  logic             irq_ready
);

   logic             req_q, armed_q, armed_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [PORTS-1:0] pending_q, pending_d, overrun_q, overrun_d, enable_q, enable_d;
   logic             proto_err_q, proto_err_d, irq_q;
   logic [NW-1:0]    irq_num_q, irq_num_d;
   state_e           state_q, state_d;

   logic             rise, fall, inRange, transfer, widthErr, anyActive;
   logic [PORTS-1:0] setVec, clrVec, active;
   logic [NW-1:0]    encIdx;

   assign active = pending_q & enable_q;

   priority_encoder #(
      .WIDTH(PORTS),
      .LSB_HIGH_PRIORITY(1'b1),
      .IDX_W(NW)
   ) u_prio (
      .req_i(active),
      .idx_o(encIdx),
      .valid_o(anyActive)
   );

   // A pulse only counts once the line has been seen low since reset, so a request
   // held across reset release is ignored until it falls and rises again.
   always_comb begin
      rise     = intr_vec_req & ~req_q & armed_q;
      fall     = ~intr_vec_req & req_q & armed_q;
      inRange  = {{(32 - NW){1'b0}}, intr_num} < 32'(PORTS);
      transfer = (state_q == PRESENT) & irq_ready;
      widthErr = fall & (cnt_q < 8'(MIN_REQ_CYCLES));
      armed_d  = armed_q | ~intr_vec_req;

      setVec = '0;
      if (rise && inRange) setVec[intr_num] = 1'b1;
      clrVec = '0;
      if (transfer) clrVec[irq_num_q] = 1'b1;

      if (rise)              cnt_d = 8'd1;
      else if (intr_vec_req) cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      else                   cnt_d = 8'd0;

      pending_d   = (pending_q & ~clrVec) | setVec;
      overrun_d   = (err_clr ? '0 : overrun_q) | (setVec & pending_q & ~clrVec);
      proto_err_d = (err_clr ? 1'b0 : proto_err_q) | (rise & ~inRange) | widthErr;
      enable_d    = en_wr ? en_wr_data : enable_q;
   end

   // Service FSM: a presentation is never pre-empted; GAP lets the pending clear settle.
   always_comb begin
      state_d   = state_q;
      irq_num_d = irq_num_q;
      case (state_q)
         IDLE: begin
            if (anyActive) begin
               irq_num_d = encIdx;
               state_d   = PRESENT;
            end
         end
         PRESENT: if (irq_ready) state_d = GAP;
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_q       <= 1'b0;
         armed_q     <= ~intr_vec_req;
         cnt_q       <= 8'd0;
         pending_q   <= '0;
         overrun_q   <= '0;
         enable_q    <= EN_RESET;
         proto_err_q <= 1'b0;
         irq_q       <= 1'b0;
         irq_num_q   <= '0;
         state_q     <= IDLE;
      end else begin
         req_q       <= intr_vec_req;
         armed_q     <= armed_d;
         cnt_q       <= cnt_d;
         pending_q   <= pending_d;
         overrun_q   <= overrun_d;
         enable_q    <= enable_d;
         proto_err_q <= proto_err_d;
         irq_q       <= anyActive;
         irq_num_q   <= irq_num_d;
         state_q     <= state_d;
      end
   end

   assign enable    = enable_q;
   assign pending   = pending_q;
   assign overrun   = overrun_q;
   assign proto_err = proto_err_q;
   assign irq       = irq_q;
   assign irq_valid = (state_q == PRESENT);
   assign irq_num   = irq_num_q;

endmodule

// File: tb/tb_intr_vec_decoder.sv
// Self-checking bench for intr_vec_decoder: directed scenarios with literal expectations,
// then randomized pulses, all compared every cycle against a behavioural model.
module tb_intr_vec_decoder;

   localparam int PORTS = 32;
   localparam int NW    = 5;
   localparam int MINW  = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             intr_vec_req = 1'b0;
   logic [NW-1:0]    intr_num = '0;
   logic             en_wr = 1'b0;
   logic [PORTS-1:0] en_wr_data = '0;
   logic [PORTS-1:0] enable, pending, overrun;
   logic             err_clr = 1'b0;
   logic             proto_err, irq, irq_valid;
   logic [NW-1:0]    irq_num;
   logic             irq_ready = 1'b0;

   int nChecks = 0;
   int nPass   = 0;
   bit checkEn = 1'b0;
   bit randomMode = 1'b0;

   intr_vec_decoder #(
      .PORTS(PORTS),
      .MIN_REQ_CYCLES(MINW),
      .EN_RESET({PORTS{1'b1}}),
      .NW(NW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .intr_vec_req(intr_vec_req),
      .intr_num(intr_num),
      .en_wr(en_wr),
      .en_wr_data(en_wr_data),
      .enable(enable),
      .pending(pending),
      .overrun(overrun),
      .err_clr(err_clr),
      .proto_err(proto_err),
      .irq(irq),
      .irq_valid(irq_valid),
      .irq_num(irq_num),
      .irq_ready(irq_ready)
   );

   always #5 clk = ~clk;

   // Behavioural model: pending set of vectors, sticky error flags, and the vector
   // currently offered to the consumer plus a one-cycle cooldown after each hand-off.
   logic [PORTS-1:0] mPend, mOvr, mEn, tP, tO;
   logic             mPerr, mIrq, mValid, mGap, mReqd, mArmed, tE;
   int               mNum, mRun, lowest, n;
   bit               rise, fall, xfer;

   always @(posedge clk) begin
      if (rst) begin
         mPend  <= '0;
         mOvr   <= '0;
         mEn    <= '1;
         mPerr  <= 1'b0;
         mIrq   <= 1'b0;
         mValid <= 1'b0;
         mGap   <= 1'b0;
         mNum   <= 0;
         mReqd  <= 1'b0;
         mRun   <= 0;
         mArmed <= !intr_vec_req;
      end else begin
         tP   = mPend;
         tO   = err_clr ? '0 : mOvr;
         tE   = err_clr ? 1'b0 : mPerr;
         rise = intr_vec_req && !mReqd && mArmed;
         fall = !intr_vec_req && mReqd && mArmed;
         xfer = mValid && irq_ready;
         if (xfer) tP[mNum] = 1'b0;
         if (rise) begin
            n = int'(intr_num);
            if (n >= PORTS) tE = 1'b1;
            else begin
               if (mPend[n] && !(xfer && mNum == n)) tO[n] = 1'b1;
               tP[n] = 1'b1;
            end
         end
         if (fall && mRun < MINW) tE = 1'b1;
         lowest = -1;
         for (int i = PORTS - 1; i >= 0; i--) if (mPend[i] && mEn[i]) lowest = i;

         mIrq <= (lowest >= 0);
         if (mValid) begin
            if (irq_ready) begin
               mValid <= 1'b0;
               mGap   <= 1'b1;
            end
         end else if (mGap) mGap <= 1'b0;
         else if (lowest >= 0) begin
            mValid <= 1'b1;
            mNum   <= lowest;
         end
         mPend  <= tP;
         mOvr   <= tO;
         mPerr  <= tE;
         mEn    <= en_wr ? en_wr_data : mEn;
         mRun   <= rise ? 1 : (intr_vec_req ? ((mRun >= 255) ? 255 : mRun + 1) : 0);
         mReqd  <= intr_vec_req;
         mArmed <= mArmed || !intr_vec_req;
      end
   end

   // Every cycle, all outputs must match the model; the number only matters while valid.
   always @(negedge clk) begin
      if (checkEn) begin
         nChecks++;
         if (pending === mPend && overrun === mOvr && enable === mEn && proto_err === mPerr &&
             irq === mIrq && irq_valid === mValid && (!mValid || int'(irq_num) == mNum))
            nPass++;
         else
            $display("[TB] FAIL model_cmp t=%0t pend=%h/%h ovr=%h/%h en=%h/%h perr=%b/%b irq=%b/%b valid=%b/%b num=%0d/%0d (actual/required)",
                     $time, pending, mPend, overrun, mOvr, enable, mEn, proto_err, mPerr,
                     irq, mIrq, irq_valid, mValid, irq_num, mNum);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual === expected) nPass++;
      else $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
   endtask

   task automatic tick();
      @(negedge clk);
      if (randomMode) begin
         irq_ready  = ($urandom_range(0, 3) != 0);
         en_wr      = ($urandom_range(0, 49) == 0);
         en_wr_data = $urandom() | $urandom();
         err_clr    = ($urandom_range(0, 29) == 0);
      end
   endtask

   task automatic applyStimulus(input int num, input int width, input int gap);
      intr_vec_req = 1'b1;
      intr_num     = NW'(num);
      repeat (width) tick();
      intr_vec_req = 1'b0;
      intr_num     = NW'($urandom_range(0, PORTS - 1));
      repeat (gap) tick();
   endtask

   initial begin
      int sel, w, g, num;
      tick();
      checkEn = 1'b1;
      tick();
      checkOutput("reset_pending", pending, 32'h0);
      checkOutput("reset_enable", enable, 32'hFFFF_FFFF);
      checkOutput("reset_valid_num", {irq_valid, irq, proto_err, 24'h0, irq_num}, 32'h0);
      rst = 1'b0;

      // Single pulse n=5 served immediately.
      irq_ready = 1'b1;
      intr_vec_req = 1'b1;
      intr_num = 5'd5;
      tick();
      checkOutput("t1_pending_after_E0", pending, 32'h20);
      tick();
      checkOutput("t1_present", {irq_valid, irq, 25'h0, irq_num}, {2'b11, 25'h0, 5'd5});
      intr_vec_req = 1'b0;
      tick();
      checkOutput("t1_pending_cleared", pending, 32'h0);
      tick();
      checkOutput("t1_irq_perr_low", {irq, proto_err}, 32'h0);

      // No pre-emption: 7 stays presented while 3 arrives.
      irq_ready = 1'b0;
      applyStimulus(7, 2, 2);
      applyStimulus(3, 2, 2);
      checkOutput("t2_hold7", {irq_valid, 26'h0, irq_num}, {1'b1, 26'h0, 5'd7});
      checkOutput("t2_pending", pending, 32'h88);
      irq_ready = 1'b1;
      tick();
      checkOutput("t2_after_xfer", {irq_valid, pending[30:0]}, {1'b0, 31'h08});
      tick();
      tick();
      checkOutput("t2_present3", {irq_valid, 26'h0, irq_num}, {1'b1, 26'h0, 5'd3});
      repeat (3) tick();

      // Overrun on a repeated vector, then cleared.
      irq_ready = 1'b0;
      applyStimulus(9, 2, 2);
      applyStimulus(9, 2, 2);
      checkOutput("t3_overrun", overrun, 32'h200);
      checkOutput("t3_pending", pending, 32'h200);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checkOutput("t3_overrun_clr", overrun, 32'h0);
      irq_ready = 1'b1;
      repeat (6) tick();

      // Short pulse flags an error but still captures; a long pulse is one clean event.
      irq_ready = 1'b0;
      applyStimulus(4, 1, 2);
      checkOutput("t4_short_perr", {proto_err, pending[30:0]}, {1'b1, 31'h10});
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      applyStimulus(6, 10, 2);
      checkOutput("t4_long", {proto_err, pending[30:0]}, {1'b0, 31'h50});
      checkOutput("t4_long_ovr", overrun, 32'h0);
      irq_ready = 1'b1;
      repeat (8) tick();

      // Masked vector is retained and served once enabled.
      irq_ready = 1'b0;
      en_wr = 1'b1;
      en_wr_data = '0;
      tick();
      en_wr = 1'b0;
      applyStimulus(2, 2, 2);
      checkOutput("t5_masked", {irq, irq_valid, pending[29:0]}, {2'b00, 30'h4});
      en_wr = 1'b1;
      en_wr_data = 32'h4;
      tick();
      en_wr = 1'b0;
      tick();
      checkOutput("t5_unmasked", {irq_valid, irq, 25'h0, irq_num}, {2'b11, 25'h0, 5'd2});
      en_wr = 1'b1;
      en_wr_data = '1;
      irq_ready = 1'b1;
      tick();
      en_wr = 1'b0;
      repeat (4) tick();

      // Transfer of 1 coinciding with a new rise of 1, then reset mid-presentation.
      irq_ready = 1'b0;
      applyStimulus(1, 2, 1);
      irq_ready = 1'b1;
      intr_vec_req = 1'b1;
      intr_num = 5'd1;
      tick();
      checkOutput("t6_collision", {irq_valid, overrun[30:0]}, 32'h0);
      checkOutput("t6_pending", pending, 32'h2);
      irq_ready = 1'b0;
      tick();
      intr_vec_req = 1'b0;
      tick();
      checkOutput("t6_represent", {irq_valid, 26'h0, irq_num}, {1'b1, 26'h0, 5'd1});
      rst = 1'b1;
      tick();
      checkOutput("t6_rst_state", {irq_valid, irq, proto_err, 24'h0, irq_num}, 32'h0);
      checkOutput("t6_rst_pending", pending | overrun, 32'h0);
      rst = 1'b0;
      tick();

      // Randomized traffic, including resets across held requests.
      randomMode = 1'b1;
      for (int k = 0; k < 400; k++) begin
         sel = $urandom_range(0, 99);
         num = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, PORTS - 1);
         if (sel < 3) begin
            intr_vec_req = 1'b1;
            intr_num = NW'(num);
            rst = 1'b1;
            tick();
            rst = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
            intr_vec_req = 1'b0;
            tick();
         end else begin
            w = (sel < 5) ? $urandom_range(200, 300) : $urandom_range(1, 4);
            g = $urandom_range(1, 3);
            applyStimulus(num, w, g);
         end
      end
      randomMode = 1'b0;
      en_wr = 1'b0;
      err_clr = 1'b0;
      irq_ready = 1'b1;
      repeat (12) tick();

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
